// File: rtl/setpoint_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | setpoint_sched_pkg                                                       |
// | Shared constants and the player state type for the setpoint scheduler.  |
// | Contents: PERIOD_MIN (smallest legal strobe period), SP_W (setpoint      |
// |           width) and the two-state player enum.                          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package setpoint_sched_pkg;

  // Smallest strobe period that still lets the interpolator's 16-cycle
  // multiply complete between updates.
  localparam int PERIOD_MIN = 20;

  // Setpoint word width, unsigned.
  localparam int SP_W = 17;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/setpoint_dpram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | setpoint_dpram                                                           |
// | Simple dual-port setpoint table: one write port, one registered read    |
// | port with 1-cycle latency. The address MSB selects the bank.            |
// | Ports: clk_i                  clock                                      |
// |        we_i/waddr_i/wdata_i   write port                                 |
// |        re_i/raddr_i           read request                               |
// |        rdata_o                read data, valid the cycle after re_i      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module setpoint_dpram #(
  parameter int AW = 5,
  parameter int DW = 17
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW:0]   waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW:0]   raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**(AW+1)];
  logic [DW-1:0] rdata_q;

  // Table contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/setpoint_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | setpoint_sched                                                           |
// | Double-buffered setpoint table player. Emits one setpoint and a         |
// | one-cycle strobe every PERIOD cycles, stepping through the active bank. |
// | Ports: clk_i, reset_i        clock, synchronous active-high reset        |
// |        wr_en_i/wr_addr_i/wr_data_i  host writes into the inactive bank  |
// |        run_i, loop_i, len_i  play control, last index played            |
// |        swap_req_i            bank swap request (deferred while playing)  |
// |        y_out_o, strobe_o     setpoint and update pulse to interpolator   |
// |        busy_o, done_o        playing / end-of-single-pass pulse          |
// |        active_bank_o         bank being played                           |
// |        swap_miss_o           sticky: swap requested while one pending    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module setpoint_sched
  import setpoint_sched_pkg::*;
#(
  parameter int PERIOD = 51,
  parameter int CNTW   = 6,
  parameter int AW     = 5
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            wr_en_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [SP_W-1:0] wr_data_i,
  input  logic            run_i,
  input  logic            loop_i,
  input  logic [AW-1:0]   len_i,
  input  logic            swap_req_i,
  output logic [SP_W-1:0] y_out_o,
  output logic            strobe_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            active_bank_o,
  output logic            swap_miss_o
);

  localparam logic [CNTW-1:0] CNT_RELOAD = CNTW'(PERIOD - 1);

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [AW-1:0]     len_q, len_d;
  logic              bank_q, bank_d;
  logic              pend_q, pend_d;
  logic              miss_q, miss_d;
  logic              fin_q, fin_d;      // final strobe issued, done due next
  logic [SP_W-1:0]   y_q, y_d;
  logic              strobe_q, strobe_d;
  logic              done_q, done_d;

  logic              ram_re;
  logic [SP_W-1:0]   ram_rdata;

  // The read is launched one cycle ahead of the strobe so the registered
  // RAM output is ready exactly when y_out is loaded.
  assign ram_re = (state_q == ST_PLAY) && (cnt_q == CNTW'(1));

  setpoint_dpram #(
    .AW (AW),
    .DW (SP_W)
  ) u_dpram (
    .clk_i   (clk_i),
    .we_i    (wr_en_i),
    .waddr_i ({~bank_q, wr_addr_i}),
    .wdata_i (wr_data_i),
    .re_i    (ram_re),
    .raddr_i ({bank_q, addr_q}),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      bank_q   <= 1'b0;
      pend_q   <= 1'b0;
      miss_q   <= 1'b0;
      fin_q    <= 1'b0;
      y_q      <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      bank_q   <= bank_d;
      pend_q   <= pend_d;
      miss_q   <= miss_d;
      fin_q    <= fin_d;
      y_q      <= y_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    len_d    = len_q;
    bank_d   = bank_q;
    pend_d   = pend_q;
    miss_d   = miss_q;
    fin_d    = fin_q;
    y_d      = y_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A request with nothing pending flips the bank at once; one that
        // lands on an existing pending swap is only flagged.
        if (swap_req_i) begin
          if (pend_q) begin
            miss_d = 1'b1;
          end else begin
            bank_d = ~bank_q;
          end
        end
        if (run_i) begin
          state_d = ST_PLAY;
          cnt_d   = CNT_RELOAD;
          addr_d  = '0;
          len_d   = len_i;
          if (pend_q) begin
            bank_d = ~bank_q;
            pend_d = 1'b0;
          end
        end
      end

      ST_PLAY: begin
        if (swap_req_i) begin
          if (pend_q) begin
            miss_d = 1'b1;
          end else begin
            pend_d = 1'b1;
          end
        end

        if (fin_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          fin_d   = 1'b0;
        end else if (cnt_q == '0) begin
          if (!run_i) begin
            // Stop on the strobe boundary without emitting it.
            state_d = ST_IDLE;
          end else begin
            strobe_d = 1'b1;
            y_d      = ram_rdata;
            cnt_d    = CNT_RELOAD;
            if (addr_q != len_q) begin
              addr_d = addr_q + AW'(1);
            end else if (loop_i) begin
              addr_d = '0;
              len_d  = len_i;
              if (pend_q) begin
                bank_d = ~bank_q;
                pend_d = 1'b0;
              end
            end else begin
              fin_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign y_out_o       = y_q;
  assign strobe_o      = strobe_q;
  assign busy_o        = (state_q == ST_PLAY);
  assign done_o        = done_q;
  assign active_bank_o = bank_q;
  assign swap_miss_o   = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_setpoint_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_setpoint_sched                                                        |
// | Self-checking bench for setpoint_sched: directed scenarios followed by  |
// | randomized stimulus, compared every cycle against a time-based model.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_setpoint_sched;
  import setpoint_sched_pkg::*;

  localparam int PERIOD = 51;
  localparam int CNTW   = 6;
  localparam int AW     = 5;
  localparam int DEPTH  = 1 << AW;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [SP_W-1:0] wr_data = '0;
  logic            run = 1'b0;
  logic            loop = 1'b0;
  logic [AW-1:0]   len = '0;
  logic            swap_req = 1'b0;
  logic [SP_W-1:0] y_out;
  logic            strobe, busy, done, active_bank, swap_miss;

  setpoint_sched #(
    .PERIOD (PERIOD),
    .CNTW   (CNTW),
    .AW     (AW)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .wr_en_i       (wr_en),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .run_i         (run),
    .loop_i        (loop),
    .len_i         (len),
    .swap_req_i    (swap_req),
    .y_out_o       (y_out),
    .strobe_o      (strobe),
    .busy_o        (busy),
    .done_o        (done),
    .active_bank_o (active_bank),
    .swap_miss_o   (swap_miss)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: absolute-time view of the player.
  bit              m_play, m_fin, m_bank, m_pend, m_miss, m_strobe, m_done;
  int              m_next, m_idx, m_last;
  logic [SP_W-1:0] m_y;
  logic [SP_W-1:0] tbl [2][DEPTH];

  // Strobe log of the current scenario.
  logic [SP_W-1:0] sq_y[$];
  bit              sq_bank[$];
  int              sq_cyc[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, act, exp);
    end
  endtask

  // Predict the effect of the coming clock edge from the inputs now applied.
  task automatic model_edge();
    bit flip;
    bit old_pend;
    int wb;
    cyc++;
    flip     = 1'b0;
    old_pend = m_pend;
    wb       = m_bank ? 0 : 1;
    m_strobe = 1'b0;
    m_done   = 1'b0;
    if (reset) begin
      m_play = 0; m_fin = 0; m_idx = 0; m_last = 0;
      m_bank = 0; m_pend = 0; m_miss = 0; m_y = '0;
    end else if (!m_play) begin
      if (swap_req) begin
        if (old_pend) m_miss = 1'b1;
        else          flip = 1'b1;
      end
      if (run) begin
        m_play = 1'b1;
        m_next = cyc + PERIOD;
        m_idx  = 0;
        m_last = int'(len);
        if (old_pend) begin
          flip   = 1'b1;
          m_pend = 1'b0;
        end
      end
      if (flip) m_bank = ~m_bank;
    end else begin
      if (m_fin) begin
        m_play = 1'b0;
        m_fin  = 1'b0;
        m_done = 1'b1;
      end else if (cyc == m_next) begin
        if (!run) begin
          m_play = 1'b0;
        end else begin
          m_strobe = 1'b1;
          m_y      = tbl[m_bank][m_idx];
          m_next   = cyc + PERIOD;
          if (m_idx != m_last) begin
            m_idx++;
          end else if (loop) begin
            m_idx  = 0;
            m_last = int'(len);
            if (old_pend) begin
              m_bank = ~m_bank;
              m_pend = 1'b0;
            end
          end else begin
            m_fin = 1'b1;
          end
        end
      end
      if (swap_req) begin
        if (old_pend) m_miss = 1'b1;
        else          m_pend = 1'b1;
      end
    end
    if (wr_en) tbl[wb][wr_addr] = wr_data;
  endtask

  // One clock with the currently applied inputs; pulse inputs self-clear.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("y_out",       32'(y_out),       32'(m_y));
    check("strobe",      32'(strobe),      32'(m_strobe));
    check("busy",        32'(busy),        32'(m_play));
    check("done",        32'(done),        32'(m_done));
    check("active_bank", 32'(active_bank), 32'(m_bank));
    check("swap_miss",   32'(swap_miss),   32'(m_miss));
    if (strobe) begin
      sq_y.push_back(y_out);
      sq_bank.push_back(active_bank);
      sq_cyc.push_back(cyc);
    end
    reset    = 1'b0;
    wr_en    = 1'b0;
    swap_req = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_entry(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = SP_W'(d);
    tick();
  endtask

  task automatic clear_log();
    sq_y.delete();
    sq_bank.delete();
    sq_cyc.delete();
  endtask

  initial begin
    int t0;
    int exp_y[$];
    int exp_b[$];

    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++) tbl[b][a] = '0;

    // Reset state.
    for (int i = 0; i < 3; i++) begin
      reset = 1'b1;
      tick();
    end
    check("rst_y_out",  32'(y_out), 0);
    check("rst_strobe", 32'(strobe), 0);
    check("rst_busy",   32'(busy), 0);
    check("rst_done",   32'(done), 0);
    check("rst_bank",   32'(active_bank), 0);
    check("rst_miss",   32'(swap_miss), 0);

    // Fill both banks with known data.
    for (int a = 0; a < DEPTH; a++) write_entry(a, int'($urandom_range(131071)));
    swap_req = 1'b1; tick();
    for (int a = 0; a < DEPTH; a++) write_entry(a, int'($urandom_range(131071)));
    swap_req = 1'b1; tick();

    // Single pass from the freshly swapped-in bank.
    for (int a = 0; a < 4; a++) write_entry(a, 100 * (a + 1));
    swap_req = 1'b1; tick();
    check("sp_bank", 32'(active_bank), 1);
    loop = 1'b0; len = AW'(3); run = 1'b1;
    clear_log();
    tick();
    t0 = cyc;
    for (int i = 0; i < 205; i++) begin
      tick();
      if (done) check("sp_done_cycle", 32'(cyc - t0), 205);
    end
    run = 1'b0;
    check("sp_busy_after", 32'(busy), 0);
    check("sp_n_strobes", 32'(sq_y.size()), 4);
    for (int i = 0; i < sq_y.size() && i < 4; i++) begin
      check("sp_strobe_cycle", 32'(sq_cyc[i] - t0), 32'(PERIOD * (i + 1)));
      check("sp_value", 32'(sq_y[i]), 32'(100 * (i + 1)));
    end
    ticks(3);

    // Looping play with a swap deferred to the wrap.
    write_entry(0, 1);
    write_entry(1, 2);
    swap_req = 1'b1; tick();
    write_entry(0, 7);
    write_entry(1, 8);
    write_entry(2, 9);
    loop = 1'b1; len = AW'(1); run = 1'b1;
    clear_log();
    tick();
    t0 = cyc;
    ticks(59);
    len = AW'(2); swap_req = 1'b1; tick();
    ticks(250);
    exp_y = '{1, 2, 7, 8, 9, 7};
    exp_b = '{0, 1, 1, 1, 1, 1};
    check("lp_n_strobes", 32'(sq_y.size()), 6);
    for (int i = 0; i < sq_y.size() && i < 6; i++) begin
      check("lp_value", 32'(sq_y[i]), 32'(exp_y[i]));
      check("lp_bank",  32'(sq_bank[i]), 32'(exp_b[i]));
    end
    run = 1'b0;
    ticks(60);
    check("lp_stopped", 32'(busy), 0);

    // Two requests in one pass: one toggle, sticky miss.
    len = AW'(2); run = 1'b1;
    clear_log();
    tick();
    t0 = cyc;
    ticks(9);
    swap_req = 1'b1; tick();
    ticks(9);
    swap_req = 1'b1; tick();
    check("ds_miss_set", 32'(swap_miss), 1);
    len = AW'(1);
    ticks(240);
    exp_y = '{7, 8, 9, 1, 2};
    exp_b = '{1, 1, 0, 0, 0};
    check("ds_n_strobes", 32'(sq_y.size()), 5);
    for (int i = 0; i < sq_y.size() && i < 5; i++) begin
      check("ds_value", 32'(sq_y[i]), 32'(exp_y[i]));
      check("ds_bank",  32'(sq_bank[i]), 32'(exp_b[i]));
    end
    run = 1'b0;
    ticks(60);
    check("ds_miss_sticky", 32'(swap_miss), 1);

    // Stop and hold.
    write_entry(1, 200);
    swap_req = 1'b1; tick();
    loop = 1'b0; len = AW'(3); run = 1'b1;
    clear_log();
    tick();
    t0 = cyc;
    ticks(102);
    check("sh_y_200", 32'(y_out), 200);
    ticks(10);
    run = 1'b0;
    ticks(40);
    check("sh_busy_before", 32'(busy), 1);
    tick();
    check("sh_busy_idle", 32'(busy), 0);
    check("sh_no_strobe", 32'(strobe), 0);
    check("sh_y_hold", 32'(y_out), 200);
    ticks(5);
    check("sh_n_strobes", 32'(sq_y.size()), 2);

    // Reset in the middle of play, then confirm the table survived.
    loop = 1'b1; len = AW'(3); run = 1'b1;
    ticks(120);
    reset = 1'b1; run = 1'b0;
    tick();
    check("mr_y_out",  32'(y_out), 0);
    check("mr_strobe", 32'(strobe), 0);
    check("mr_busy",   32'(busy), 0);
    check("mr_bank",   32'(active_bank), 0);
    loop = 1'b0; len = AW'(0); run = 1'b1;
    clear_log();
    tick();
    ticks(52);
    run = 1'b0;
    check("mr_n_strobes", 32'(sq_y.size()), 1);
    if (sq_y.size() > 0) check("mr_table_kept", 32'(sq_y[0]), 1);
    ticks(3);

    // Strobe spacing over 1000 updates of a single entry.
    loop = 1'b1; len = AW'(0); run = 1'b1;
    clear_log();
    tick();
    t0 = cyc;
    ticks(1000 * PERIOD);
    check("sc_n_strobes", 32'(sq_cyc.size()), 1000);
    if (sq_cyc.size() > 0) check("sc_first", 32'(sq_cyc[0] - t0), 32'(PERIOD));
    for (int i = 1; i < sq_cyc.size(); i++)
      check("sc_interval", 32'(sq_cyc[i] - sq_cyc[i-1]), 32'(PERIOD));
    run = 1'b0;
    ticks(60);

    // Randomized stimulus against the model.
    run = 1'b1;
    for (int i = 0; i < 12000; i++) begin
      if ($urandom_range(99) < 30) begin
        wr_en   = 1'b1;
        wr_addr = AW'($urandom);
        wr_data = SP_W'($urandom);
      end
      if ($urandom_range(199) == 0) swap_req = 1'b1;
      if ($urandom_range(299) == 0) run = ~run;
      if ($urandom_range(499) == 0) loop = ~loop;
      if ($urandom_range(99) == 0) len = AW'($urandom_range(7));
      if ($urandom_range(4999) == 0) reset = 1'b1;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/setpoint_sched.md
# setpoint_sched

Double-buffered setpoint table player that feeds the smoothing interpolator. Emits one 17-bit setpoint and a one-cycle `strobe` every `period` clock cycles, stepping through a host-loaded table, so the interpolator always sees evenly spaced updates. Sits between the host register bus (table writes, run/loop/swap controls) and the interpolator's `y_in`/`strobe` inputs.

## Interface
- `period`, 51: cycles between strobes; must equal the interpolator's coherent period; legal range 20..2^`cntw`.
- `cntw`, 6: period counter width, ceil(log2(`period`)).
- `aw`, 5: table address width; each bank holds 2^`aw` entries.
- `clk`  in  1  single clock, all logic rising-edge.
- `reset`  in  1  synchronous, active-high.
- `wr_en`  in  1  host table write strobe.
- `wr_addr`  in  `aw`  host write address, always into the inactive bank.
- `wr_data`  in  17  setpoint, unsigned.
- `run`  in  1  level; 1 = play, 0 = stop at the next strobe boundary.
- `loop`  in  1  1 = wrap at `len`, 0 = single pass.
- `len`  in  `aw`  index of the last entry played; sampled at every wrap and at IDLE→PLAY.
- `swap_req`  in  1  pulse; makes the inactive bank active at the next wrap.
- `y_out`  out  17  setpoint to interpolator `y_in`, held between strobes.
- `strobe`  out  1  one-cycle update pulse to interpolator.
- `busy`  out  1  high in PLAY.
- `done`  out  1  one-cycle pulse when a single pass ends.
- `active_bank`  out  1  bank currently being played.
- `swap_miss`  out  1  sticky; `swap_req` arrived while a swap was already pending. Cleared only by reset.

## Operation
- States: IDLE, PLAY.
- **IDLE**
  - `run`=1 → PLAY.
  - Load the period counter with `period`-1, set addr=0, latch `len`.
  - A pending swap is applied immediately on this transition.
- **PLAY**
  - Counter decrements each cycle.
  - When the counter is 0: assert `strobe`, load `y_out` with table[`active_bank`][addr], reload the counter with `period`-1, then advance addr.
- **Addr advance at a strobe**
  - addr≠`len`: addr+1.
  - addr=`len`, `loop`=1: addr=0, re-latch `len`, apply the pending swap.
  - addr=`len`, `loop`=0: pulse `done` next cycle, go to IDLE.
- **`run`=0 in PLAY:** no further strobes. Return to IDLE at the cycle the counter would have reached 0, with no strobe in that cycle. `y_out` holds its last value.
- **Swap requests**
  - `swap_req` in IDLE: toggle `active_bank` the next cycle.
  - `swap_req` in PLAY: set `swap_pend`.
  - `swap_req` while `swap_pend`=1: set `swap_miss`; the request is not queued twice.
- **Host writes:** always land in bank ~`active_bank`, including the cycle a swap takes effect. A write in the swap cycle uses the pre-swap bank.
- **Arithmetic:** the counter and addr are unsigned and wrap only as described, never by overflow. `len`=0 plays entry 0 every period.
- **Reset values:** all outputs 0, `active_bank`=0, state IDLE, counter 0, addr 0, `swap_pend`=0. Table contents are not reset.

## Timing
- First strobe comes exactly `period` cycles after the cycle `run` is first sampled high in IDLE.
- Strobe spacing is exactly `period` cycles while `run`=1. `strobe` and the new `y_out` appear in the same cycle.
- The table is a synchronous RAM with 1-cycle read latency. The read is issued when the counter is 1, so `y_out` needs no extra stage.
- `period`≥20 guarantees the interpolator's 16-cycle multiply finishes before the next strobe.
- `done` is one cycle after the final strobe. `busy` falls in the same cycle as `done`.
- Reset mid-PLAY: the next cycle shows IDLE with all outputs 0 and no trailing strobe.

## Structure
- Shared package: `PERIOD_MIN`=20, setpoint width 17, and the state enum (IDLE, PLAY).
- One sub-module, `setpoint_dpram`: 2^(`aw`+1)×17 simple dual-port RAM with one write port and one read port, 1-cycle read latency. Bank select is the address MSB.
- Everything else (FSM, counter, addr, swap logic) lives in the top level.

## Test plan
- **Single pass:** `period`=51, `len`=3, `loop`=0, inactive bank = {100, 200, 300, 400}, `swap_req` then `run`=1.
  - Required: strobes at cycles 51/102/153/204 carrying 100/200/300/400, `done` at 205, `busy` low from 205.
- **Loop with deferred swap:** play bank0 = {1, 2} looping; load bank1 = {7, 8, 9} with `len`=2; pulse `swap_req` mid-pass.
  - Required: the sequence continues 1, 2, then 7, 8, 9, 7, …; `active_bank` toggles at the wrap strobe only.
- **Double swap:** two `swap_req` pulses within one pass.
  - Required: `swap_miss`=1 and remains set; exactly one toggle at the wrap.
- **Stop and hold:** deassert `run` 10 cycles after a strobe with `y_out`=200.
  - Required: no further strobes; IDLE 41 cycles later; `y_out` holds 200.
- **Reset mid-PLAY:** assert `reset` for one cycle during PLAY.
  - Required: next cycle `y_out`=0, `strobe`=0, `busy`=0, `active_bank`=0; the table still reads back its old data after a restart.
- **Spacing check:** `len`=0, `loop`=1, run for 1000 strobes.
  - Required: every strobe interval is exactly 51 cycles.
